// File: rtl/node_loss.sv
// Output-layer error source: err[i] = tgt[i] - act[i] and a running sum of e^2 over samples.
// Latency: M+1 cycles from the last vector capture to output_backward_valid (or to readies back high when train=0).
// Backpressure: readies are low outside LOAD; EMIT holds valid and data until output_backward_ready.
module node_loss #(
    parameter int M  = 2,
    parameter int LW = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            train,
    input  logic            input_forward_valid,
    input  logic [M*8-1:0]  input_forward_data,
    output logic            input_forward_ready,
    input  logic            target_valid,
    input  logic [M*8-1:0]  target_data,
    output logic            target_ready,
    output logic            output_backward_valid,
    output logic [M*16-1:0] output_backward_data,
    input  logic            output_backward_ready,
    input  logic            loss_clear,
    output logic [LW-1:0]   loss_data,
    output logic [15:0]     loss_count
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    state_t              state, state_nx;
    logic                act_held, tgt_held;
    logic [M-1:0][7:0]   act_q, tgt_q;
    logic [M-1:0][15:0]  err_q;
    logic [CW-1:0]       cnt;

    logic signed [8:0]   e;
    logic [8:0]          e_abs;
    logic [15:0]         sq;
    logic [LW:0]         loss_sum;

    // Readies depend only on registered state, never on the valids.
    assign input_forward_ready   = (state == LOAD) && !act_held;
    assign target_ready          = (state == LOAD) && !tgt_held;
    assign output_backward_valid = (state == EMIT);
    assign output_backward_data  = err_q;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nx;
    end

    // Next-state: both vectors held starts a pass; train is only looked at on the last element.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (act_held && tgt_held) state_nx = CALC;
            CALC: if (cnt == LAST) state_nx = train ? EMIT : LOAD;
            EMIT: if (output_backward_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Per-element error and its square; squaring the magnitude keeps the product unsigned.
    always_comb begin
        e        = $signed({1'b0, tgt_q[cnt]}) - $signed({1'b0, act_q[cnt]});
        e_abs    = e[8] ? 9'(-e) : 9'(e);
        sq       = e_abs[7:0] * e_abs[7:0];
        loss_sum = {1'b0, loss_data} + (LW+1)'(sq);
    end

    // Vector capture: each channel latches on its own handshake and waits for the other.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            act_held <= 1'b0;
            tgt_held <= 1'b0;
            act_q    <= '0;
            tgt_q    <= '0;
        end else if (state == LOAD) begin
            if (act_held && tgt_held) begin
                act_held <= 1'b0;
                tgt_held <= 1'b0;
            end else begin
                if (input_forward_valid && input_forward_ready) begin
                    act_q    <= input_forward_data;
                    act_held <= 1'b1;
                end
                if (target_valid && target_ready) begin
                    tgt_q    <= target_data;
                    tgt_held <= 1'b1;
                end
            end
        end
    end

    // Element walk: one error written per CALC cycle, sign-extended to 16 bits.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt   <= '0;
            err_q <= '0;
        end else if (state == CALC) begin
            err_q[cnt] <= {{7{e[8]}}, e};
            cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Loss tally: clear wins over a same-cycle accumulate; both values saturate.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loss_data  <= '0;
            loss_count <= '0;
        end else if (loss_clear) begin
            loss_data  <= '0;
            loss_count <= '0;
        end else if (state == CALC) begin
            loss_data <= loss_sum[LW] ? {LW{1'b1}} : loss_sum[LW-1:0];
            if (cnt == LAST && loss_count != 16'hFFFF)
                loss_count <= loss_count + 16'd1;
        end
    end

endmodule
